// File: rtl/multi_clock_generator.sv
// NUM_CH runtime-programmable clock dividers / tick generators off sysClk.
// Config writes land in a shadow copy and take effect glitch-free at terminal count, when idle, or on syncIn.
module multi_clock_generator #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int CH_W         = 2,
  parameter int DEFAULT_DIV  = 24999,
  parameter int DEFAULT_EN   = 1,
  parameter int DEFAULT_MODE = 0
) (
  input  logic              sysClk,
  input  logic              sysRst_n,
  input  logic              cfgValid,
  output logic              cfgReady,
  input  logic [CH_W-1:0]   cfgCh,
  input  logic [CNT_W-1:0]  cfgDiv,
  input  logic              cfgMode,
  input  logic              cfgEn,
  output logic              cfgErr,
  input  logic              syncIn,
  output logic [NUM_CH-1:0] dividedClock,
  output logic [NUM_CH-1:0] tick
);

  localparam int               CH_SPACE = 2 ** CH_W;
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic             DEF_EN   = 1'(DEFAULT_EN);
  localparam logic             DEF_MODE = 1'(DEFAULT_MODE);

  logic [CNT_W-1:0]  cnt_r    [NUM_CH];
  logic [CNT_W-1:0]  actDiv_r [NUM_CH];
  logic [CNT_W-1:0]  shDiv_r  [NUM_CH];
  logic [NUM_CH-1:0] actMode_r, actEn_r, shMode_r, shEn_r, pend_r, clk_r, tick_r;
  logic              cfgErr_r;

  logic [CH_SPACE-1:0] pendWide_s;
  logic                inRange_s, cfgReady_s, accept_s;
  logic [NUM_CH-1:0]   running_s, tc_s, apply_s, modeChg_s, keepPhase_s, wr_s;

  // Handshake decode and per-channel terminal-count / apply decisions
  always_comb begin
    pendWide_s                = '0;
    pendWide_s[NUM_CH-1:0]    = pend_r;
    inRange_s                 = ({1'b0, cfgCh} < NUM_CH_L);
    cfgReady_s                = sysRst_n && (!inRange_s || !pendWide_s[cfgCh]);
    accept_s                  = cfgValid && cfgReady_s;
    running_s                 = '0;
    tc_s                      = '0;
    apply_s                   = '0;
    modeChg_s                 = '0;
    keepPhase_s               = '0;
    wr_s                      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // a disabled toggle channel still high runs on to its next TC so the high phase is never cut short
      running_s[c]   = actEn_r[c] | (clk_r[c] & ~actMode_r[c]);
      tc_s[c]        = running_s[c] && (cnt_r[c] == actDiv_r[c]);
      apply_s[c]     = pend_r[c] && (syncIn || tc_s[c] || !running_s[c]);
      modeChg_s[c]   = (shMode_r[c] != actMode_r[c]);
      keepPhase_s[c] = tc_s[c] && !modeChg_s[c] && shEn_r[c];
      wr_s[c]        = accept_s && inRange_s && (cfgCh == CH_W'(c));
    end
  end

  // Channel state: shadow/active config, counters and output flops
  always_ff @(posedge sysClk) begin
    if (!sysRst_n) begin
      cfgErr_r <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_r[c]     <= '0;
        actDiv_r[c]  <= DEF_DIV;
        shDiv_r[c]   <= DEF_DIV;
        actMode_r[c] <= DEF_MODE;
        shMode_r[c]  <= DEF_MODE;
        actEn_r[c]   <= DEF_EN;
        shEn_r[c]    <= DEF_EN;
        pend_r[c]    <= 1'b0;
        clk_r[c]     <= 1'b0;
        tick_r[c]    <= 1'b0;
      end
    end else begin
      cfgErr_r <= accept_s && !inRange_s;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_s[c]) begin
          shDiv_r[c]  <= cfgDiv;
          shMode_r[c] <= cfgMode;
          shEn_r[c]   <= cfgEn;
        end
        pend_r[c] <= wr_s[c] | (pend_r[c] & ~apply_s[c]);
        if (apply_s[c]) begin
          actDiv_r[c]  <= shDiv_r[c];
          actMode_r[c] <= shMode_r[c];
          actEn_r[c]   <= shEn_r[c];
        end
        if (syncIn) begin
          cnt_r[c]  <= '0;
          clk_r[c]  <= 1'b0;
          tick_r[c] <= 1'b0;
        end else if (apply_s[c]) begin
          // same-mode, still-enabled apply at TC keeps the waveform continuous; anything else restarts low
          cnt_r[c]  <= '0;
          clk_r[c]  <= keepPhase_s[c] && !actMode_r[c] && !clk_r[c];
          tick_r[c] <= keepPhase_s[c] && actMode_r[c];
        end else if (tc_s[c]) begin
          cnt_r[c]  <= '0;
          clk_r[c]  <= !actMode_r[c] && !clk_r[c];
          tick_r[c] <= actMode_r[c] && actEn_r[c];
        end else if (running_s[c]) begin
          cnt_r[c]  <= cnt_r[c] + CNT_W'(1);
          tick_r[c] <= 1'b0;
        end else begin
          cnt_r[c]  <= '0;
          clk_r[c]  <= 1'b0;
          tick_r[c] <= 1'b0;
        end
      end
    end
  end

  assign cfgReady     = cfgReady_s;
  assign cfgErr       = cfgErr_r;
  assign dividedClock = clk_r;
  assign tick         = tick_r;

endmodule

// File: tb/tb_multi_clock_generator.sv
// Scoreboard bench for multi_clock_generator: a segment-based reference model predicts every
// cycle's outputs, the stimulus pushes them into a queue and a negedge monitor compares.
module tb_multi_clock_generator;

  localparam int NUM  = 3;
  localparam int CHW  = 2;
  localparam int CW   = 16;
  localparam int DDIV = 5;

  logic            sysClk   = 1'b0;
  logic            sysRst_n = 1'b0;
  logic            cfgValid = 1'b0;
  logic [CHW-1:0]  cfgCh    = '0;
  logic [CW-1:0]   cfgDiv   = '0;
  logic            cfgMode  = 1'b0;
  logic            cfgEn    = 1'b0;
  logic            syncIn   = 1'b0;
  logic            cfgReady, cfgErr;
  logic [NUM-1:0]  dividedClock, tick;

  multi_clock_generator #(
    .NUM_CH(NUM), .CNT_W(CW), .CH_W(CHW), .DEFAULT_DIV(DDIV), .DEFAULT_EN(1), .DEFAULT_MODE(0)
  ) dut (
    .sysClk(sysClk), .sysRst_n(sysRst_n), .cfgValid(cfgValid), .cfgReady(cfgReady),
    .cfgCh(cfgCh), .cfgDiv(cfgDiv), .cfgMode(cfgMode), .cfgEn(cfgEn), .cfgErr(cfgErr),
    .syncIn(syncIn), .dividedClock(dividedClock), .tick(tick)
  );

  always #5 sysClk = ~sysClk;

  typedef struct packed {
    logic [NUM-1:0] clk;
    logic [NUM-1:0] tk;
    logic           err;
    logic           rdy;
  } exp_t;
  exp_t sbQ[$];

  int total = 0;
  int bad   = 0;
  int edgeN = 0;

  // Reference model: each channel is described by the edge where its counter last restarted
  // (segStart) plus the output values on that edge; everything later follows by division.
  int mDiv[NUM], sDiv[NUM], segStart[NUM];
  bit mMode[NUM], mEn[NUM], sMode[NUM], sEn[NUM], mPend[NUM], segClk[NUM], segTick[NUM];
  bit mErr = 1'b0;
  bit pRst = 1'b0, pAcc = 1'b0, pSync = 1'b0, pMode = 1'b0, pEn = 1'b0;
  int pCh = 0, pDiv = 0;

  function automatic bit expClk(int c, int n);
    int k, p;
    k = n - segStart[c];
    p = mDiv[c] + 1;
    if (k == 0) return segClk[c];
    if (!mEn[c] || mMode[c]) return 1'b0;
    return segClk[c] ^ (((k / p) % 2) == 1);
  endfunction

  function automatic bit expTick(int c, int n);
    int k, p;
    k = n - segStart[c];
    p = mDiv[c] + 1;
    if (k == 0) return segTick[c];
    return mEn[c] && mMode[c] && ((k % p) == 0);
  endfunction

  task automatic modelEdge(int n);
    bit pre, tc, mc;
    int k, p;
    if (!pRst) begin
      mErr = 1'b0;
      for (int c = 0; c < NUM; c++) begin
        mDiv[c] = DDIV; sDiv[c] = DDIV;
        mMode[c] = 1'b0; sMode[c] = 1'b0;
        mEn[c] = 1'b1; sEn[c] = 1'b1;
        mPend[c] = 1'b0;
        segStart[c] = n; segClk[c] = 1'b0; segTick[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM; c++) begin
        pre = expClk(c, n - 1);
        k   = n - segStart[c];
        p   = mDiv[c] + 1;
        tc  = mEn[c] && (k > 0) && ((k % p) == 0);
        if (pSync) begin
          if (mPend[c]) begin
            mDiv[c] = sDiv[c]; mMode[c] = sMode[c]; mEn[c] = sEn[c]; mPend[c] = 1'b0;
          end
          segStart[c] = n; segClk[c] = 1'b0; segTick[c] = 1'b0;
        end else if (mPend[c] && (tc || !mEn[c])) begin
          mc          = (sMode[c] != mMode[c]);
          segClk[c]   = tc && !mc && sEn[c] && !mMode[c] && !pre;
          segTick[c]  = tc && !mc && sEn[c] && mMode[c];
          segStart[c] = n;
          mDiv[c] = sDiv[c]; mMode[c] = sMode[c]; mEn[c] = sEn[c]; mPend[c] = 1'b0;
        end
      end
      mErr = pAcc && (pCh >= NUM);
      if (pAcc && (pCh < NUM)) begin
        sDiv[pCh] = pDiv; sMode[pCh] = pMode; sEn[pCh] = pEn; mPend[pCh] = 1'b1;
      end
    end
  endtask

  // One clock: advance the model over the edge just taken, drive the next inputs, queue the expectation
  task automatic step(bit rst, bit v, int ch, int dv, bit md, bit en, bit sy);
    exp_t e;
    bit   r;
    @(posedge sysClk);
    #1;
    modelEdge(edgeN);
    for (int c = 0; c < NUM; c++) begin
      e.clk[c] = expClk(c, edgeN);
      e.tk[c]  = expTick(c, edgeN);
    end
    e.err = mErr;
    edgeN++;
    sysRst_n = rst; cfgValid = v; cfgCh = CHW'(ch); cfgDiv = CW'(dv);
    cfgMode = md; cfgEn = en; syncIn = sy;
    if (!rst)           r = 1'b0;
    else if (ch >= NUM) r = 1'b1;
    else                r = !mPend[ch];
    e.rdy = r;
    pRst = rst; pAcc = v && r; pCh = ch; pDiv = dv; pMode = md; pEn = en; pSync = sy;
    sbQ.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(int ch, int dv, bit md, bit en);
    step(1'b1, 1'b1, ch, dv, md, en, 1'b0);
  endtask

  task automatic syncHold(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(string name, logic [NUM-1:0] got, logic [NUM-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, edgeN, got, want);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; pop one expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge sysClk);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        check("dividedClock", dividedClock, e.clk);
        check("tick", tick, e.tk);
        check("cfgErr", NUM'(cfgErr), NUM'(e.err));
        check("cfgReady", NUM'(cfgReady), NUM'(e.rdy));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog edge=%0d", edgeN);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(40);
    wr(1, 3, 1'b0, 1'b1);           idle(40);
    wr(2, 4, 1'b1, 1'b1);           idle(30);
    wr(2, 0, 1'b1, 1'b1);           idle(20);
    wr(0, 5, 1'b0, 1'b0);           idle(30);
    wr(0, 1, 1'b0, 1'b1);           idle(20);
    wr(0, 2, 1'b0, 1'b1);
    wr(1, 5, 1'b0, 1'b1);
    wr(2, 9, 1'b0, 1'b1);           idle(40);
    syncHold(1);                    idle(40);
    syncHold(5);                    idle(30);
    wr(3, 7, 1'b1, 1'b1);           idle(5);
    wr(1, 7, 1'b1, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1, 2, 1'b1, 1'b1, 1'b0);
    idle(30);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3),
           $urandom_range(0, 9), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0);
    end
    idle(2);
    @(negedge sysClk);
    @(negedge sysClk);
    #1;
    total++;
    if (sbQ.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
